// File: rtl/sync_fifo_pkg.sv
// Shared width helpers and parameter-legality check for the sync_fifo_thresh family.
package sync_fifo_pkg;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit params_ok(input int unsigned depth, input int unsigned width,
                                    input int unsigned af_level, input int unsigned ae_level);
      return (depth >= 2) && (width >= 1) && (af_level >= 1) && (af_level <= depth) &&
             (ae_level < depth) && (ae_level < af_level);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
// Storage is never reset; only the read register and its valid strobe are.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PTR_W = ptr_w(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr_en,
   input  logic [PTR_W-1:0] i_wr_ptr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [PTR_W-1:0] i_rd_ptr,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_rd_valid
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;
   logic             r_rd_valid;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= i_rd_en;
         if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_ptr];
         end
      end
   end

   assign o_rd_data  = r_rd_data;
   assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and registered read.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky OVERFLOW/UNDERFLOW logic.
module sync_fifo_thresh
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned AF_LEVEL = DEPTH - 1,
   parameter int unsigned AE_LEVEL = 1,
   parameter int unsigned CNT_W    = cnt_w(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             WR_EN,
   input  logic             RD_EN,
   output logic [WIDTH-1:0] DATA_OUT,
   output logic             DATA_VALID,
   output logic [CNT_W-1:0] CNTR,
   output logic             EMPTY,
   output logic             FULL,
   output logic             ALMOST_EMPTY,
   output logic             ALMOST_FULL,
   output logic             OVERFLOW,
   output logic             UNDERFLOW
);

   localparam int unsigned      PTR_W    = ptr_w(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

   if (!params_ok(DEPTH, WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
      $fatal(1, "sync_fifo_thresh: illegal DEPTH/WIDTH/AF_LEVEL/AE_LEVEL combination");
   end

   logic [CNT_W-1:0] r_cntr;
   logic [CNT_W-1:0] w_cntr_nxt;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             w_empty;
   logic             w_full;
   logic             w_rd_acc;
   logic             w_wr_acc;

   assign w_empty  = (r_cntr == '0);
   assign w_full   = (r_cntr == FULL_CNT);
   assign w_rd_acc = RD_EN && !w_empty;
   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign w_wr_acc = WR_EN && (!w_full || w_rd_acc);

   always_comb begin
      w_cntr_nxt = r_cntr;
      if (w_wr_acc && !w_rd_acc) begin
         w_cntr_nxt = r_cntr + CNT_W'(1);
      end else if (!w_wr_acc && w_rd_acc) begin
         w_cntr_nxt = r_cntr - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cntr   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_cntr <= w_cntr_nxt;
         if (w_wr_acc) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
         end
      end
   end

   sync_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_wr_en    (w_wr_acc),
      .i_wr_ptr   (r_wr_ptr),
      .i_wr_data  (DATA_IN),
      .i_rd_en    (w_rd_acc),
      .i_rd_ptr   (r_rd_ptr),
      .o_rd_data  (DATA_OUT),
      .o_rd_valid (DATA_VALID)
   );

   assign CNTR         = r_cntr;
   assign EMPTY        = w_empty;
   assign FULL         = w_full;
   assign ALMOST_FULL  = (r_cntr >= AF_CNT);
   assign ALMOST_EMPTY = (r_cntr <= AE_CNT);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (WR_EN && !w_wr_acc) begin
            r_overflow <= 1'b1;
         end
         // A read racing the first write into an empty FIFO is not counted as an underflow.
         if (RD_EN && w_empty && !w_wr_acc) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign OVERFLOW  = r_overflow;
   assign UNDERFLOW = r_underflow;
`else
   assign OVERFLOW  = 1'b0;
   assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench for sync_fifo_thresh with DEPTH=6, AF_LEVEL=5, AE_LEVEL=1.
module tb_sync_fifo_thresh;

   localparam int unsigned DEPTH = 6;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned AF    = 5;
   localparam int unsigned AE    = 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RST;
   logic [WIDTH-1:0] DATA_IN;
   logic             WR_EN;
   logic             RD_EN;
   logic [WIDTH-1:0] DATA_OUT;
   logic             DATA_VALID;
   logic [CNT_W-1:0] CNTR;
   logic             EMPTY;
   logic             FULL;
   logic             ALMOST_EMPTY;
   logic             ALMOST_FULL;
   logic             OVERFLOW;
   logic             UNDERFLOW;

   int n_checks = 0;
   int n_errors = 0;

   sync_fifo_thresh #(
      .DEPTH    (DEPTH),
      .WIDTH    (WIDTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .DATA_IN      (DATA_IN),
      .WR_EN        (WR_EN),
      .RD_EN        (RD_EN),
      .DATA_OUT     (DATA_OUT),
      .DATA_VALID   (DATA_VALID),
      .CNTR         (CNTR),
      .EMPTY        (EMPTY),
      .FULL         (FULL),
      .ALMOST_EMPTY (ALMOST_EMPTY),
      .ALMOST_FULL  (ALMOST_FULL),
      .OVERFLOW     (OVERFLOW),
      .UNDERFLOW    (UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit         rst;
      bit         wr;
      bit         rd;
      logic [7:0] din;
      int         cntr;
      bit         valid;
      logic [7:0] dout;
      bit         ovf;
      bit         unf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs; outputs are sampled 1 time unit after the rising edge.
   task automatic step(input bit rst, input bit wr, input bit rd, input logic [7:0] din);
      RST     = rst;
      WR_EN   = wr;
      RD_EN   = rd;
      DATA_IN = din;
      @(posedge CLK);
      #1;
   endtask

   task automatic check_state(input string tag, input int cntr, input bit valid,
                              input logic [7:0] dout, input bit ovf, input bit unf);
      chk({tag, " cntr"},  32'(CNTR), 32'(cntr));
      chk({tag, " empty"}, 32'(EMPTY), 32'(cntr == 0));
      chk({tag, " full"},  32'(FULL), 32'(cntr == DEPTH));
      chk({tag, " aempty"}, 32'(ALMOST_EMPTY), 32'(cntr <= AE));
      chk({tag, " afull"}, 32'(ALMOST_FULL), 32'(cntr >= AF));
      chk({tag, " valid"}, 32'(DATA_VALID), 32'(valid));
      chk({tag, " dout"},  32'(DATA_OUT), 32'(dout));
      chk({tag, " ovf"},   32'(OVERFLOW), 32'(ovf & ERR_EN));
      chk({tag, " unf"},   32'(UNDERFLOW), 32'(unf & ERR_EN));
   endtask

   initial begin
      RST     = 1'b1;
      WR_EN   = 1'b0;
      RD_EN   = 1'b0;
      DATA_IN = '0;

      //                rst wr rd din    cntr v dout   ovf unf
      vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0});
      vecs.push_back('{0, 1, 0, 8'h11, 1, 0, 8'h00, 0, 0});
      vecs.push_back('{0, 1, 0, 8'h22, 2, 0, 8'h00, 0, 0});
      vecs.push_back('{0, 1, 0, 8'h33, 3, 0, 8'h00, 0, 0});
      vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0});
      vecs.push_back('{0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 1});
      vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0});
      for (int i = 1; i <= 6; i++) begin
         vecs.push_back('{0, 1, 0, 8'(i), i, 0, 8'h00, 0, 0});
      end
      for (int i = 1; i <= 3; i++) begin
         vecs.push_back('{0, 0, 1, 8'h00, 6 - i, 1, 8'(i), 0, 0});
      end
      for (int i = 7; i <= 9; i++) begin
         vecs.push_back('{0, 1, 0, 8'(i), i - 3, 0, 8'h03, 0, 0});
      end
      for (int i = 4; i <= 9; i++) begin
         vecs.push_back('{0, 0, 1, 8'h00, 9 - i, 1, 8'(i), 0, 0});
      end
      vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h09, 0, 0});

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
         check_state($sformatf("vec%0d", i), vecs[i].cntr, vecs[i].valid, vecs[i].dout,
                     vecs[i].ovf, vecs[i].unf);
      end

      // Full with simultaneous read and write: the write is taken, 0xAA comes out last.
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, 8'(8'h10 + i));
      end
      check_state("fullrw_pre", 6, 0, 8'h00, 0, 0);
      step(0, 1, 1, 8'hAA);
      check_state("fullrw", 6, 1, 8'h10, 0, 0);
      for (int i = 1; i <= 6; i++) begin
         step(0, 0, 1, 8'h00);
         check_state($sformatf("fullrw_rd%0d", i), 6 - i, 1,
                     (i == 6) ? 8'hAA : 8'(8'h10 + i), 0, 0);
      end

      // Full with write only: rejected, sticky overflow, contents untouched.
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, 8'(8'h20 + i));
      end
      step(0, 1, 0, 8'h77);
      check_state("fullwr", 6, 0, 8'hAA, 1, 0);
      step(0, 0, 0, 8'h00);
      check_state("fullwr_hold", 6, 0, 8'hAA, 1, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1, 8'h00);
         check_state($sformatf("fullwr_rd%0d", i), 5 - i, 1, 8'(8'h20 + i), 1, 0);
      end
      step(1, 0, 0, 8'h00);
      check_state("rst_clr", 0, 0, 8'h00, 0, 0);

      // Empty with simultaneous read and write: stores one entry, outputs nothing.
      step(0, 1, 1, 8'h5C);
      check_state("emptyrw", 1, 0, 8'h00, 0, 0);
      step(0, 0, 1, 8'h00);
      check_state("emptyrw_rd", 0, 1, 8'h5C, 0, 0);

      // Threshold sweep up and down; flag expectations come from check_state.
      step(1, 0, 0, 8'h00);
      for (int i = 1; i <= 6; i++) begin
         step(0, 1, 0, 8'(i));
         check_state($sformatf("sweep_up%0d", i), i, 0, 8'h00, 0, 0);
      end
      for (int i = 1; i <= 6; i++) begin
         step(0, 0, 1, 8'h00);
         check_state($sformatf("sweep_dn%0d", i), 6 - i, 1, 8'(i), 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
